// File: rtl/seq_detector_param_pkg.sv
// Shared constants and mode encoding for the parametrised serial pattern detector.
package seq_det_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data + host configuration bus of the pattern detector.
interface seq_detector_param_if #(
    parameter int MAX_LEN = seq_det_pkg::MAX_LEN_DEF,
    parameter int CNT_W   = 16
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               din_valid;
    logic               din;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               cfg_err;
    logic               match;
    logic               match_q;
    logic [CNT_W-1:0]   match_count;

    modport master (
        output din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        input  cfg_err, match, match_q, match_count
    );

    modport slave (
        input  din_valid, din, cfg_load, cfg_pattern, cfg_len, cfg_overlap,
        output cfg_err, match, match_q, match_count
    );
endinterface

// File: rtl/seq_detector_param_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern/length, overlap mode,
// same-cycle Mealy match, registered match and saturating match counter.
module seq_detector_param import seq_det_pkg::*; #(
    parameter int                 MAX_LEN     = MAX_LEN_DEF,
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1001),
    parameter int                 DEF_LEN     = 4,
    parameter bit                 DEF_OVERLAP = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_detector_param_if.slave  bus
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic [LW-1:0]      len_q, len_d;
    mode_e              mode_q, mode_d;
    logic               cfgErr_q, cfgErr_d;
    logic               matchQ_q;

    logic [MAX_LEN-1:0] lenMask;
    logic [MAX_LEN-1:0] shifted;
    logic               accept;
    logic               cfgOk;
    logic               fillOk;
    logic               patOk;
    logic               matchNow;
    logic               cntClr;
    logic [CNT_W-1:0]   count;

    // Only the low len bits of the window take part in the comparison.
    always_comb begin
        lenMask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            lenMask[i] = (i < int'(len_q));
        end
    end

    assign shifted  = {hist_q[MAX_LEN-2:0], bus.din};
    assign accept   = bus.din_valid & ~bus.cfg_load;
    assign cfgOk    = (bus.cfg_len != '0) && (int'(bus.cfg_len) <= MAX_LEN);
    assign fillOk   = (int'(fill_q) + 1) >= int'(len_q);
    assign patOk    = ((shifted ^ pattern_q) & lenMask) == '0;
    assign matchNow = accept & fillOk & patOk;
    assign cntClr   = bus.cfg_load & cfgOk;

    always_comb begin
        hist_d    = hist_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        len_d     = len_q;
        mode_d    = mode_q;
        cfgErr_d  = bus.cfg_load & ~cfgOk;
        if (bus.cfg_load) begin
            if (cfgOk) begin
                pattern_d = bus.cfg_pattern;
                len_d     = bus.cfg_len;
                mode_d    = mode_e'(bus.cfg_overlap);
                hist_d    = '0;
                fill_d    = '0;
            end
        end else if (bus.din_valid) begin
            hist_d = shifted;
            // Non-overlapping mode restarts the fill so the next match needs len fresh bits.
            if (matchNow && (mode_q == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (int'(fill_q) < MAX_LEN) begin
                fill_d = fill_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q    <= '0;
            fill_q    <= '0;
            pattern_q <= DEF_PATTERN;
            len_q     <= LW'(DEF_LEN);
            mode_q    <= mode_e'(DEF_OVERLAP);
            cfgErr_q  <= 1'b0;
            matchQ_q  <= 1'b0;
        end else begin
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            cfgErr_q  <= cfgErr_d;
            matchQ_q  <= matchNow;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_matchCount (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (matchNow),
        .clr_i   (cntClr),
        .count_o (count)
    );

    assign bus.match       = matchNow;
    assign bus.match_q     = matchQ_q;
    assign bus.cfg_err     = cfgErr_q;
    assign bus.match_count = count;
endmodule

// File: tb/tb_seq_detector_param.sv
// Directed, table-driven bench for seq_detector_param; a second instance with a
// 2-bit counter covers saturation.
module tb_seq_detector_param;

    typedef struct {
        logic valid;
        logic din;
        logic expMatch;
        int   expCount;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       dinValid;
    logic       din;
    logic       cfgLoad;
    logic [7:0] cfgPattern;
    logic [3:0] cfgLen;
    logic       cfgOverlap;

    int   compared   = 0;
    int   mismatched = 0;
    bit   useSmall   = 1'b0;
    vec_t tbl[$];

    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(16)) busA ();
    seq_detector_param_if #(.MAX_LEN(8), .CNT_W(2))  busB ();

    assign busA.din_valid   = dinValid;
    assign busA.din         = din;
    assign busA.cfg_load    = cfgLoad;
    assign busA.cfg_pattern = cfgPattern;
    assign busA.cfg_len     = cfgLen;
    assign busA.cfg_overlap = cfgOverlap;
    assign busB.din_valid   = dinValid;
    assign busB.din         = din;
    assign busB.cfg_load    = cfgLoad;
    assign busB.cfg_pattern = cfgPattern;
    assign busB.cfg_len     = cfgLen;
    assign busB.cfg_overlap = cfgOverlap;

    seq_detector_param #(.MAX_LEN(8), .CNT_W(16)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    always #5 clk = ~clk;

    function automatic int curMatch();
        return useSmall ? int'(busB.match) : int'(busA.match);
    endfunction

    function automatic int curMatchQ();
        return useSmall ? int'(busB.match_q) : int'(busA.match_q);
    endfunction

    function automatic int curErr();
        return useSmall ? int'(busB.cfg_err) : int'(busA.cfg_err);
    endfunction

    function automatic int curCount();
        return useSmall ? int'(busB.match_count) : int'(busA.match_count);
    endfunction

    function automatic vec_t mk(input logic v, input logic d, input logic m, input int c);
        vec_t t;
        t.valid    = v;
        t.din      = d;
        t.expMatch = m;
        t.expCount = c;
        return t;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic d);
        @(negedge clk);
        dinValid = v;
        din      = d;
        cfgLoad  = 1'b0;
    endtask

    // Mealy match is checked before the edge, registered outputs just after it.
    task automatic runVec(input vec_t t, input string tag);
        applyStimulus(t.valid, t.din);
        #1;
        checkOutput({tag, " match"}, curMatch(), int'(t.expMatch));
        @(posedge clk);
        #1;
        checkOutput({tag, " match_q"}, curMatchQ(), int'(t.expMatch));
        checkOutput({tag, " count"}, curCount(), t.expCount);
    endtask

    task automatic runTable(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i], $sformatf("%s[%0d]", name, i));
        end
        tbl.delete();
    endtask

    task automatic doLoad(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                          input logic withValid, input logic expErr, input int expCount,
                          input string tag);
        @(negedge clk);
        cfgLoad    = 1'b1;
        cfgPattern = pat;
        cfgLen     = len;
        cfgOverlap = ovl;
        dinValid   = withValid;
        din        = 1'b1;
        #1;
        checkOutput({tag, " match during load"}, curMatch(), 0);
        @(posedge clk);
        #1;
        checkOutput({tag, " cfg_err"}, curErr(), int'(expErr));
        checkOutput({tag, " count"}, curCount(), expCount);
        @(negedge clk);
        cfgLoad  = 1'b0;
        dinValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " cfg_err pulse end"}, curErr(), 0);
    endtask

    task automatic doReset(input logic withLoad, input string tag);
        @(negedge clk);
        rst        = 1'b1;
        dinValid   = 1'b1;
        din        = 1'b1;
        cfgLoad    = withLoad;
        cfgPattern = 8'b0000_0111;
        cfgLen     = 4'd3;
        cfgOverlap = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, " count"}, curCount(), 0);
        checkOutput({tag, " match_q"}, curMatchQ(), 0);
        checkOutput({tag, " cfg_err"}, curErr(), 0);
        @(negedge clk);
        rst      = 1'b0;
        cfgLoad  = 1'b0;
        dinValid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        dinValid   = 1'b0;
        din        = 1'b0;
        cfgLoad    = 1'b0;
        cfgPattern = '0;
        cfgLen     = '0;
        cfgOverlap = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset match_q", curMatchQ(), 0);
        checkOutput("reset count", curCount(), 0);
        checkOutput("reset cfg_err", curErr(), 0);
        checkOutput("reset match", curMatch(), 0);
        @(negedge clk);
        rst = 1'b0;

        // Default 1001 non-overlapping
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1)); tbl.push_back(mk(1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1));
        runTable("defNonOvl");

        // 1001 overlapping
        doLoad(8'b0000_1001, 4'd4, 1'b1, 1'b0, 1'b0, 0, "ld1001ovl");
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 0, 1)); tbl.push_back(mk(1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 2));
        runTable("ovl1001");

        // 111 with junk above len, overlapping then non-overlapping
        doLoad(8'b1010_0111, 4'd3, 1'b1, 1'b0, 1'b0, 0, "ld111ovl");
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1)); tbl.push_back(mk(1, 1, 1, 2));
        tbl.push_back(mk(1, 1, 1, 3));
        runTable("ovl111");
        doLoad(8'b1010_0111, 4'd3, 1'b0, 1'b0, 1'b0, 0, "ld111nonovl");
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 1, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1)); tbl.push_back(mk(1, 1, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1));
        runTable("nonovl111");

        // Rejected loads keep pattern, mode, history, fill and count
        doLoad(8'h00, 4'd0, 1'b1, 1'b0, 1'b1, 1, "lenZero");
        doLoad(8'h00, 4'd9, 1'b1, 1'b0, 1'b1, 1, "lenNine");
        tbl.push_back(mk(1, 1, 1, 2)); tbl.push_back(mk(1, 1, 0, 2));
        tbl.push_back(mk(1, 1, 0, 2));
        runTable("afterErr");

        // Load together with a valid bit: the bit is dropped
        doLoad(8'b0000_1001, 4'd4, 1'b0, 1'b1, 1'b0, 0, "ldWithValid");
        tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 1));
        runTable("droppedBit");

        // Reset after 3 of 4 bits, with a load competing against reset
        tbl.push_back(mk(1, 1, 0, 1)); tbl.push_back(mk(1, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1));
        runTable("preReset");
        doReset(1'b1, "midReset");
        tbl.push_back(mk(1, 1, 0, 0)); tbl.push_back(mk(1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0)); tbl.push_back(mk(1, 1, 1, 1));
        runTable("postReset");

        // Valid gaps inside the pattern
        tbl.push_back(mk(1, 1, 0, 1)); tbl.push_back(mk(0, 1, 0, 1));
        tbl.push_back(mk(1, 0, 0, 1)); tbl.push_back(mk(0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 1)); tbl.push_back(mk(1, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 2));
        runTable("gapped");

        // Two-bit counter saturation with a single-bit pattern
        useSmall = 1'b1;
        doReset(1'b0, "smallReset");
        doLoad(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, 0, "ldLen1");
        tbl.push_back(mk(1, 1, 1, 1)); tbl.push_back(mk(1, 1, 1, 2));
        tbl.push_back(mk(1, 1, 1, 3)); tbl.push_back(mk(1, 1, 1, 3));
        tbl.push_back(mk(1, 1, 1, 3)); tbl.push_back(mk(1, 1, 1, 3));
        tbl.push_back(mk(1, 0, 0, 3));
        runTable("satLen1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
